// File: rtl/rv_regfile_pkg.sv
// Shared constants for the datapath register file.
//   REG_COUNT  : number of architectural registers (x00..x31)
//   REG_ADDR_W : width of a register index
//   ZERO_REG   : index of the hardwired-zero register
package rv_regfile_pkg;

  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage : rv_regfile_pkg

// File: rtl/decoder_5_to_32.sv
// One-hot write-select decoder, the inverse of mux32.
// Ports:
//   ena : when 0 the output is all-zero
//   in  : 5-bit index to decode
//   out : 32-bit one-hot select, bit[in] set when ena=1
module decoder_5_to_32
  import rv_regfile_pkg::*;
(
  input  logic                  ena,
  input  logic [REG_ADDR_W-1:0] in,
  output logic [REG_COUNT-1:0]  out
);

  always_comb begin
    out = '0;
    if (ena) begin
      out[in] = 1'b1;
    end
  end

endmodule : decoder_5_to_32

// File: rtl/mux32.sv
// 32-input, N-bit wide combinational selector used by the read ports.
// Ports:
//   sel     : 5-bit input select
//   d00..d31: data inputs
//   out     : selected data input
module mux32 #(
  parameter int unsigned N = 32
) (
  input  logic [4:0]   sel,
  input  logic [N-1:0] d00, input logic [N-1:0] d01,
  input  logic [N-1:0] d02, input logic [N-1:0] d03,
  input  logic [N-1:0] d04, input logic [N-1:0] d05,
  input  logic [N-1:0] d06, input logic [N-1:0] d07,
  input  logic [N-1:0] d08, input logic [N-1:0] d09,
  input  logic [N-1:0] d10, input logic [N-1:0] d11,
  input  logic [N-1:0] d12, input logic [N-1:0] d13,
  input  logic [N-1:0] d14, input logic [N-1:0] d15,
  input  logic [N-1:0] d16, input logic [N-1:0] d17,
  input  logic [N-1:0] d18, input logic [N-1:0] d19,
  input  logic [N-1:0] d20, input logic [N-1:0] d21,
  input  logic [N-1:0] d22, input logic [N-1:0] d23,
  input  logic [N-1:0] d24, input logic [N-1:0] d25,
  input  logic [N-1:0] d26, input logic [N-1:0] d27,
  input  logic [N-1:0] d28, input logic [N-1:0] d29,
  input  logic [N-1:0] d30, input logic [N-1:0] d31,
  output logic [N-1:0] out
);

  always_comb begin
    out = d00;
    case (sel)
      5'd0:  out = d00;
      5'd1:  out = d01;
      5'd2:  out = d02;
      5'd3:  out = d03;
      5'd4:  out = d04;
      5'd5:  out = d05;
      5'd6:  out = d06;
      5'd7:  out = d07;
      5'd8:  out = d08;
      5'd9:  out = d09;
      5'd10: out = d10;
      5'd11: out = d11;
      5'd12: out = d12;
      5'd13: out = d13;
      5'd14: out = d14;
      5'd15: out = d15;
      5'd16: out = d16;
      5'd17: out = d17;
      5'd18: out = d18;
      5'd19: out = d19;
      5'd20: out = d20;
      5'd21: out = d21;
      5'd22: out = d22;
      5'd23: out = d23;
      5'd24: out = d24;
      5'd25: out = d25;
      5'd26: out = d26;
      5'd27: out = d27;
      5'd28: out = d28;
      5'd29: out = d29;
      5'd30: out = d30;
      5'd31: out = d31;
      default: out = d00;
    endcase
  end

endmodule : mux32

// File: rtl/register_file.sv
// 32-entry datapath register file, one write port and two combinational
// read ports. x00 is hardwired to zero and has no storage.
// Ports:
//   clk               : rising-edge clock
//   rst               : synchronous active-high reset, clears x01..x31
//   wr_ena            : write enable
//   wr_addr, wr_data  : destination index and data (stored unmodified)
//   rd_addr0/rd_data0 : read port 0 (combinational, no write bypass)
//   rd_addr1/rd_data1 : read port 1 (combinational, no write bypass)
// There is no handshake: every edge with wr_ena=1 commits a write, and a
// read of the register being written shows the old value until that edge.
module register_file
  import rv_regfile_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_ena,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]          wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr0,
  output logic [N-1:0]          rd_data0,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  output logic [N-1:0]          rd_data1
);

  logic [REG_COUNT-1:0] wr_sel;
  logic [N-1:0]         reg_val [REG_COUNT];

  decoder_5_to_32 u_wr_dec (
    .ena (wr_ena),
    .in  (wr_addr),
    .out (wr_sel)
  );

  // x00 has no flop, so its decoded select line goes nowhere.
  logic unused_sel0;
  assign unused_sel0 = wr_sel[ZERO_REG];
  assign reg_val[0]  = '0;

  for (genvar k = 1; k < REG_COUNT; k++) begin : g_reg
    logic [N-1:0] reg_q;
    logic [N-1:0] reg_d;

    always_comb begin
      reg_d = reg_q;
      if (wr_sel[k]) begin
        reg_d = wr_data;
      end
    end

    // Reset dominates any write on the same edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign reg_val[k] = reg_q;
  end

  mux32 #(.N(N)) u_rd_mux0 (
    .sel (rd_addr0),
    .d00 ('0),          .d01 (reg_val[1]),  .d02 (reg_val[2]),  .d03 (reg_val[3]),
    .d04 (reg_val[4]),  .d05 (reg_val[5]),  .d06 (reg_val[6]),  .d07 (reg_val[7]),
    .d08 (reg_val[8]),  .d09 (reg_val[9]),  .d10 (reg_val[10]), .d11 (reg_val[11]),
    .d12 (reg_val[12]), .d13 (reg_val[13]), .d14 (reg_val[14]), .d15 (reg_val[15]),
    .d16 (reg_val[16]), .d17 (reg_val[17]), .d18 (reg_val[18]), .d19 (reg_val[19]),
    .d20 (reg_val[20]), .d21 (reg_val[21]), .d22 (reg_val[22]), .d23 (reg_val[23]),
    .d24 (reg_val[24]), .d25 (reg_val[25]), .d26 (reg_val[26]), .d27 (reg_val[27]),
    .d28 (reg_val[28]), .d29 (reg_val[29]), .d30 (reg_val[30]), .d31 (reg_val[31]),
    .out (rd_data0)
  );

  mux32 #(.N(N)) u_rd_mux1 (
    .sel (rd_addr1),
    .d00 ('0),          .d01 (reg_val[1]),  .d02 (reg_val[2]),  .d03 (reg_val[3]),
    .d04 (reg_val[4]),  .d05 (reg_val[5]),  .d06 (reg_val[6]),  .d07 (reg_val[7]),
    .d08 (reg_val[8]),  .d09 (reg_val[9]),  .d10 (reg_val[10]), .d11 (reg_val[11]),
    .d12 (reg_val[12]), .d13 (reg_val[13]), .d14 (reg_val[14]), .d15 (reg_val[15]),
    .d16 (reg_val[16]), .d17 (reg_val[17]), .d18 (reg_val[18]), .d19 (reg_val[19]),
    .d20 (reg_val[20]), .d21 (reg_val[21]), .d22 (reg_val[22]), .d23 (reg_val[23]),
    .d24 (reg_val[24]), .d25 (reg_val[25]), .d26 (reg_val[26]), .d27 (reg_val[27]),
    .d28 (reg_val[28]), .d29 (reg_val[29]), .d30 (reg_val[30]), .d31 (reg_val[31]),
    .out (rd_data1)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, sweep, x00, enable gating,
// read-during-write with reset priority, dual-port tracking.
module tb_register_file;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_ena;
  logic [4:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [4:0]   rd_addr0;
  logic [W-1:0] rd_data0;
  logic [4:0]   rd_addr1;
  logic [W-1:0] rd_data1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q [$];

  // clock / reset block
  always #5 clk = ~clk;

  register_file #(.N(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_data0 (rd_data0),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [W-1:0] d);
    wr_ena  = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_ena  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    write_reg(5'd5, 32'hDEADBEEF);
    rd_addr0 = 5'd5;
    #1;
    checks++;
    if (rd_data0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_prewrite: got %h expected %h", rd_data0, 32'hDEADBEEF);
    end
    do_reset();
    checks++;
    if (rd_data0 !== '0) begin
      errors++;
      $display("FAIL reset_x05: got %h expected 0", rd_data0);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr0 = 5'(a);
      rd_addr1 = 5'(31 - a);
      #1;
      checks++;
      if (rd_data0 !== '0 || rd_data1 !== '0) begin
        errors++;
        $display("FAIL reset_all a=%0d: got %h/%h expected 0/0", a, rd_data0, rd_data1);
      end
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] vals [32];
    logic [W-1:0] exp;
    vals[0] = '0;
    for (int a = 1; a < 32; a++) begin
      vals[a] = $random;
      vals[a][4:0] = 5'(a); // keep every value distinct
      write_reg(5'(a), vals[a]);
    end
    for (int a = 0; a < 32; a++) exp_q.push_back(vals[a]);
    for (int a = 0; a < 32; a++) begin
      exp = exp_q.pop_front();
      rd_addr0 = 5'(a);
      rd_addr1 = 5'(a);
      #1;
      checks++;
      if (rd_data0 !== exp) begin
        errors++;
        $display("FAIL sweep_p0 a=%0d: got %h expected %h", a, rd_data0, exp);
      end
      checks++;
      if (rd_data1 !== exp) begin
        errors++;
        $display("FAIL sweep_p1 a=%0d: got %h expected %h", a, rd_data1, exp);
      end
    end
  endtask

  task automatic test_x00();
    write_reg(5'd0, 32'hFFFFFFFF);
    rd_addr0 = 5'd0;
    rd_addr1 = 5'd0;
    #1;
    checks++;
    if (rd_data0 !== '0 || rd_data1 !== '0) begin
      errors++;
      $display("FAIL x00_immutable: got %h/%h expected 0/0", rd_data0, rd_data1);
    end
  endtask

  task automatic test_enable_gating();
    write_reg(5'd7, 32'h12345678);
    wr_ena   = 1'b0;
    wr_addr  = 5'd7;
    wr_data  = 32'hCAFEF00D;
    rd_addr0 = 5'd7;
    repeat (3) tick();
    checks++;
    if (rd_data0 !== 32'h12345678) begin
      errors++;
      $display("FAIL enable_gating: got %h expected %h", rd_data0, 32'h12345678);
    end
  endtask

  task automatic test_rdw_reset_priority();
    write_reg(5'd9, 32'h11);
    wr_ena   = 1'b1;
    wr_addr  = 5'd9;
    wr_data  = 32'h22;
    rd_addr0 = 5'd9;
    #1;
    checks++;
    if (rd_data0 !== 32'h11) begin
      errors++;
      $display("FAIL rdw_before: got %h expected %h", rd_data0, 32'h11);
    end
    tick();
    checks++;
    if (rd_data0 !== 32'h22) begin
      errors++;
      $display("FAIL rdw_after: got %h expected %h", rd_data0, 32'h22);
    end
    write_reg(5'd9, 32'h11);
    wr_ena  = 1'b1;
    wr_data = 32'h22;
    rst     = 1'b1;
    #1;
    checks++;
    if (rd_data0 !== 32'h11) begin
      errors++;
      $display("FAIL rst_prio_before: got %h expected %h", rd_data0, 32'h11);
    end
    tick();
    rst    = 1'b0;
    wr_ena = 1'b0;
    checks++;
    if (rd_data0 !== '0) begin
      errors++;
      $display("FAIL rst_prio_after: got %h expected 0", rd_data0);
    end
    // first edge after reset accepts a write
    write_reg(5'd9, 32'h33);
    checks++;
    if (rd_data0 !== 32'h33) begin
      errors++;
      $display("FAIL post_reset_write: got %h expected %h", rd_data0, 32'h33);
    end
  endtask

  task automatic test_dual_port();
    logic [W-1:0] prev;
    write_reg(5'd30, 32'hA5A5A5A5);
    write_reg(5'd3, 32'h50);
    prev = 32'h50;
    rd_addr0 = 5'd3;
    rd_addr1 = 5'd30;
    for (int i = 0; i < 4; i++) begin
      wr_ena  = 1'b1;
      wr_addr = 5'd3;
      wr_data = 32'h100 + 32'(i);
      #1;
      checks++;
      if (rd_data0 !== prev) begin
        errors++;
        $display("FAIL dual_pre i=%0d: got %h expected %h", i, rd_data0, prev);
      end
      tick();
      prev = 32'h100 + 32'(i);
      checks++;
      if (rd_data0 !== prev || rd_data1 !== 32'hA5A5A5A5) begin
        errors++;
        $display("FAIL dual_post i=%0d: got %h/%h expected %h/%h",
                 i, rd_data0, rd_data1, prev, 32'hA5A5A5A5);
      end
    end
    rd_addr1 = 5'd3;
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'h200 + 32'(i);
      #1;
      checks++;
      if (rd_data0 !== prev || rd_data1 !== prev) begin
        errors++;
        $display("FAIL same_pre i=%0d: got %h/%h expected %h", i, rd_data0, rd_data1, prev);
      end
      tick();
      prev = 32'h200 + 32'(i);
      checks++;
      if (rd_data0 !== prev || rd_data1 !== prev) begin
        errors++;
        $display("FAIL same_post i=%0d: got %h/%h expected %h", i, rd_data0, rd_data1, prev);
      end
    end
    wr_ena   = 1'b0;
    rd_addr1 = 5'd30;
    #1;
    checks++;
    if (rd_data1 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL x30_unchanged: got %h expected %h", rd_data1, 32'hA5A5A5A5);
    end
  endtask

  initial begin
    rst      = 1'b0;
    wr_ena   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr0 = '0;
    rd_addr1 = '0;
    #2;
    test_reset();
    test_sweep();
    test_x00();
    test_enable_gating();
    test_rdw_reset_priority();
    test_dual_port();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_register_file

// File: doc/register_file.md
# register_file

Write side of the 32-entry datapath register storage. A 5→32 one-hot write decoder selects which of 32 N-bit registers captures `wr_data` on a clock edge. Two independent read ports return register contents combinationally through the existing `mux32` selector. The block sits between the ALU result bus and the ALU operand inputs of the core datapath.

## Interface
Parameters:
- `N`, default 32: register width in bits.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `wr_ena`, input, 1: write enable.
- `wr_addr`, input, 5: destination register index.
- `wr_data`, input, N: data to write.
- `rd_addr0`, input, 5: read port 0 index.
- `rd_data0`, output, N: contents of register `rd_addr0`.
- `rd_addr1`, input, 5: read port 1 index.
- `rd_data1`, output, N: contents of register `rd_addr1`.

## Operation
- Storage is 32 registers, `x00`..`x31`, each N bits wide.
- `x00` is hardwired to zero:
  - Writes to address 0 are discarded.
  - Reading address 0 always returns 0.
  - No flop is required for `x00`.
- Write decode: `wr_ena` and `wr_addr` produce a one-hot 32-bit enable vector. It is all-zero when `wr_ena`=0. Exactly one bit is set when `wr_ena`=1.
- Register k updates to `wr_data` on the rising edge when `rst`=0, `wr_ena`=1, `wr_addr`=k and k≠0. All other registers hold their value.
- Reset:
  - If `rst`=1 at a rising edge, every register becomes 0, regardless of `wr_ena`. Reset dominates write.
  - Reset asserted mid-sequence clears everything on that edge. The first write after reset deasserts is accepted on the first edge where `rst`=0.
- Reads:
  - Purely combinational from the current register state.
  - Both ports are independent and may address the same register.
  - No write-to-read bypass: reading the address being written returns the old value until the edge, then the new value.
- Width rule: `wr_data` is stored unmodified. There is no truncation or extension inside the block.

## Timing
- Write latency: 1 cycle. Data presented with `wr_ena` before edge T is visible on a read port immediately after edge T.
- Read latency: 0 cycles, combinational from `rd_addr*` and state. The path is decoder-free and goes through `mux32` only.
- Output values:
  - Immediately after any reset edge, `rd_data0` and `rd_data1` are 0 for every address.
  - Before the first reset, contents are undefined except `x00`, which is 0.
- Back-to-back writes to the same address on consecutive edges: the last write wins. Each intermediate value is visible for exactly one cycle.
- No stall or handshake. A write is accepted on every enabled edge.

## Structure
- Shared package `rv_regfile_pkg` contains:
  - `REG_COUNT` = 32
  - `REG_ADDR_W` = 5
  - `ZERO_REG` = 5'd0
- Sub-module `decoder_5_to_32`:
  - Inputs: `ena` and a 5-bit `in`.
  - Output: 32-bit one-hot `out`.
  - It is the inverse of `mux32` and is instantiated once for the write port.
- Read ports instantiate two `mux32 #(.N(N))`, with `d00` tied to 0.
- Registers are built from a generate loop, k=1..31, of enabled flops with synchronous clear.

## Test plan
- **Reset clear:**
  - Stimulus: write 32'hDEADBEEF to x05, then assert `rst` for one edge.
  - Required response: `rd_data0` with `rd_addr0`=5 reads 0, and all 32 addresses read 0.
- **Full sweep:**
  - Stimulus: write a distinct `$random` value to each of x01..x31, then read every address on both ports.
  - Required response: each register returns its written value, and x00 returns 0.
- **x00 immutability:**
  - Stimulus: `wr_ena`=1, `wr_addr`=0, `wr_data`=32'hFFFFFFFF, one edge.
  - Required response: `rd_data0` and `rd_data1` at address 0 both read 0.
- **Enable gating:**
  - Stimulus: x07 holds 32'h12345678; apply `wr_ena`=0, `wr_addr`=7, `wr_data`=32'hCAFEF00D for 3 edges.
  - Required response: x07 still reads 32'h12345678.
- **Read-during-write and reset priority:**
  - Stimulus: x09 holds 32'h11; drive `wr_addr`=9, `wr_data`=32'h22, `rd_addr0`=9.
  - Required response: `rd_data0` is 32'h11 before the edge and 32'h22 after it.
  - Stimulus: repeat with `rst`=1 on the same edge.
  - Required response: x09 reads 0 after that edge.
- **Dual-port independence:**
  - Stimulus: set `rd_addr0`=3 and `rd_addr1`=30 (and both ports = 3) while writing x03 each cycle with incrementing data.
  - Required response: both ports track correctly with 1-cycle write latency, and x30 is unchanged.
